// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared encodings, widths and reset constants for the data-memory controller
package dmem_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam state_t            RST_STATE = ST_IDLE;
    localparam logic [DATA_W-1:0] RST_WORD  = '0;
    localparam logic [REG_AW-1:0] RST_REG   = '0;

    // Size 2'b11 behaves as a word everywhere, including the alignment check.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  is_misaligned = 1'b0;
            SIZE_H:  is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - store lane replication / byte enables and load lane extraction / extension
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[7:0];
        case (addr_lo)
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Low address bits below natural alignment are ignored, which masks misaligned accesses.
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = wdata;
        ld_data   = rdata;
        case (size)
            SIZE_B: begin
                mem_be    = 4'b0001 << addr_lo;
                mem_wdata = {4{wdata[7:0]}};
                ld_data   = unsigned_ld ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SIZE_H: begin
                mem_be    = 4'b0011 << {addr_lo[1], 1'b0};
                mem_wdata = {2{wdata[15:0]}};
                ld_data   = unsigned_ld ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = wdata;
                ld_data   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data RAM controller with ack timeout; MISALIGN_TRAP_EN traps misaligned half/word
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqMem,
    input  logic              reqWe,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [DATA_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWdata,
    input  logic              reqRegWe,
    input  logic [REG_AW-1:0] reqRegAddr,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [3:0]        memBe,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic              wbValid,
    output logic              wbRegWe,
    output logic [REG_AW-1:0] wbRegAddr,
    output logic [DATA_W-1:0] wbData,
    output logic              err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t              state, state_nx;
    logic                rst_done;
    logic [7:0]          to_cnt;
    logic                accept, misalign, timeout, regwe_in;
    logic                lat_we, lat_uns, lat_regwe;
    logic [1:0]          lat_size;
    logic [DATA_W-1:0]   lat_addr, lat_wdata;
    logic [REG_AW-1:0]   lat_regaddr;
    logic [DATA_W-1:0]   lane_wdata, lane_ld;
    logic [3:0]          lane_be;

    assign accept   = reqValid && reqReady;
    assign regwe_in = reqRegWe && (reqRegAddr != '0);

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_misaligned(reqSize, reqAddr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    dmem_lane u_lane (
        .size        (lat_size),
        .unsigned_ld (lat_uns),
        .addr_lo     (lat_addr[1:0]),
        .wdata       (lat_wdata),
        .rdata       (memRdata),
        .mem_wdata   (lane_wdata),
        .mem_be      (lane_be),
        .ld_data     (lane_ld)
    );

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            state    <= RST_STATE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nx;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            ST_IDLE: if (accept && reqMem) state_nx = misalign ? ST_DONE : ST_BUS;
            ST_BUS: begin
                if (memAck) begin
                    state_nx = ST_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = ST_IDLE;
                    timeout  = 1'b1;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        reqReady = (state == ST_IDLE) && rst_done;
        memReq   = (state == ST_BUS);
        memWe    = memReq && lat_we;
        memAddr  = memReq ? {lat_addr[31:2], 2'b00} : RST_WORD;
        memWdata = (memReq && lat_we) ? lane_wdata : RST_WORD;
        memBe    = memReq ? lane_be : 4'b0000;
    end

    // The counter is held at zero outside BUS, so it always starts clean on entry.
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            to_cnt      <= 8'd0;
            lat_we      <= 1'b0;
            lat_uns     <= 1'b0;
            lat_regwe   <= 1'b0;
            lat_size    <= SIZE_B;
            lat_addr    <= RST_WORD;
            lat_wdata   <= RST_WORD;
            lat_regaddr <= RST_REG;
        end else begin
            to_cnt <= (state == ST_BUS) ? to_cnt + 8'd1 : 8'd0;
            if (state == ST_IDLE && accept && reqMem) begin
                lat_we      <= reqWe;
                lat_uns     <= reqUnsigned;
                lat_regwe   <= regwe_in;
                lat_size    <= reqSize;
                lat_addr    <= reqAddr;
                lat_wdata   <= reqWdata;
                lat_regaddr <= reqRegAddr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            wbValid   <= 1'b0;
            wbRegWe   <= 1'b0;
            wbRegAddr <= RST_REG;
            wbData    <= RST_WORD;
            err       <= 1'b0;
        end else begin
            wbValid   <= 1'b0;
            wbRegWe   <= 1'b0;
            wbRegAddr <= RST_REG;
            wbData    <= RST_WORD;
            err       <= 1'b0;
            if (state == ST_IDLE && accept && !reqMem) begin
                wbValid   <= 1'b1;
                wbRegWe   <= regwe_in;
                wbRegAddr <= reqRegAddr;
                wbData    <= reqAddr;
            end else if (state == ST_IDLE && accept && misalign) begin
                wbValid   <= 1'b1;
                wbRegAddr <= reqRegAddr;
                err       <= 1'b1;
            end else if (state == ST_BUS && memAck) begin
                wbValid   <= 1'b1;
                wbRegWe   <= lat_regwe && !lat_we;
                wbRegAddr <= lat_regaddr;
                wbData    <= lat_we ? RST_WORD : lane_ld;
            end else if (timeout) begin
                wbValid   <= 1'b1;
                wbRegAddr <= lat_regaddr;
                err       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        resetIn = 1'b0;
    logic        reqValid = 1'b0, reqReady;
    logic        reqMem = 1'b0, reqWe = 1'b0, reqUnsigned = 1'b0, reqRegWe = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic [31:0] reqAddr = '0, reqWdata = '0;
    logic [4:0]  reqRegAddr = '0;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memBe;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;
    logic        wbValid, wbRegWe, err;
    logic [4:0]  wbRegAddr;
    logic [31:0] wbData;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetIn(resetIn),
        .reqValid(reqValid), .reqReady(reqReady), .reqMem(reqMem), .reqWe(reqWe),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .reqRegWe(reqRegWe), .reqRegAddr(reqRegAddr),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
        .memAck(memAck), .memRdata(memRdata),
        .wbValid(wbValid), .wbRegWe(wbRegWe), .wbRegAddr(wbRegAddr), .wbData(wbData), .err(err)
    );

    task automatic drive_req(input logic mem, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic regwe, input logic [4:0] regaddr);
        reqValid = 1'b1; reqMem = mem; reqWe = we; reqSize = size; reqUnsigned = uns;
        reqAddr = addr; reqWdata = wdata; reqRegWe = regwe; reqRegAddr = regaddr;
    endtask

    task automatic test_reset;
        resetIn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({reqReady, memReq, memWe, memBe, wbValid, wbRegWe, err} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {reqReady, memReq, memWe, memBe, wbValid, wbRegWe, err});
        end
        checks++;
        if ({memAddr, memWdata, wbData, wbRegAddr} !== 101'b0) begin
            failures++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", memAddr, memWdata, wbData, wbRegAddr);
        end
        resetIn = 1'b1;
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", reqReady); end
    endtask

    task automatic test_passthrough;
        drive_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
        @(negedge clk);
        checks++;
        if ({wbValid, wbRegWe, wbRegAddr, wbData} !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin
            failures++;
            $display("FAIL pass1 got=%b %b %0d %h exp=1 1 5 00001234", wbValid, wbRegWe, wbRegAddr, wbData);
        end
        drive_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_5678, 32'h0, 1'b1, 5'd0);
        @(negedge clk);
        checks++;
        if ({wbValid, wbRegWe, wbData} !== {1'b1, 1'b0, 32'h0000_5678}) begin
            failures++;
            $display("FAIL pass_b2b_r0 got=%b %b %h exp=1 0 00005678", wbValid, wbRegWe, wbData);
        end
        reqValid = 1'b0;
        @(negedge clk);
        checks++;
        if (wbValid !== 1'b0) begin failures++; $display("FAIL pass_pulse_end got=%b exp=0", wbValid); end
    endtask

    task automatic test_store_byte;
        drive_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 1'b1, 5'd7);
        @(negedge clk);
        reqValid = 1'b0;
        checks++;
        if ({memReq, memWe, memAddr, memBe, memWdata, reqReady} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1'b0}) begin
            failures++;
            $display("FAIL store_bus got=%b %b %h %b %h %b exp=1 1 00000100 1000 abababab 0",
                     memReq, memWe, memAddr, memBe, memWdata, reqReady);
        end
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        checks++;
        if ({memReq, wbValid, wbRegWe, err} !== 4'b0100) begin
            failures++;
            $display("FAIL store_done got=%b exp=0100", {memReq, wbValid, wbRegWe, err});
        end
        @(negedge clk);
        checks++;
        if ({reqReady, wbValid} !== 2'b10) begin failures++; $display("FAIL store_idle got=%b exp=10", {reqReady, wbValid}); end
    endtask

    task automatic test_load(input string name, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rdata, input int delay,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        drive_req(1'b1, 1'b0, size, uns, addr, 32'h0, 1'b1, 5'd9);
        @(negedge clk);
        reqValid = 1'b0;
        checks++;
        if ({memReq, memWe, memAddr, memBe} !== {1'b1, 1'b0, {addr[31:2], 2'b00}, exp_be}) begin
            failures++;
            $display("FAIL %s_bus got=%b %b %h %b exp=1 0 %h %b", name, memReq, memWe, memAddr, memBe,
                     {addr[31:2], 2'b00}, exp_be);
        end
        repeat (delay) @(negedge clk);
        memAck = 1'b1; memRdata = rdata;
        @(negedge clk);
        memAck = 1'b0; memRdata = 32'h0;
        checks++;
        if ({memReq, wbValid, wbRegWe, wbRegAddr, wbData, err} !== {1'b0, 1'b1, 1'b1, 5'd9, exp_data, 1'b0}) begin
            failures++;
            $display("FAIL %s_wb got=%b %b %b %0d %h %b exp=0 1 1 9 %h 0", name, memReq, wbValid, wbRegWe,
                     wbRegAddr, wbData, err, exp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int  bus_cycles = 0;
        bit  seen = 0;
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 5'd4);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            reqValid = 1'b0;
            if (memReq) bus_cycles++;
            if (err) begin
                seen = 1;
                checks++;
                if ({wbValid, wbRegWe, wbData, reqReady, memReq} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL timeout_wb got=%b %b %h %b %b exp=1 0 00000000 1 0",
                             wbValid, wbRegWe, wbData, reqReady, memReq);
                end
            end
        end
        checks++;
        if (!seen || bus_cycles != 16) begin
            failures++;
            $display("FAIL timeout_len got=seen%0d cycles%0d exp=seen1 cycles16", seen, bus_cycles);
        end
        @(negedge clk);
        checks++;
        if ({err, wbValid} !== 2'b00) begin failures++; $display("FAIL timeout_pulse got=%b exp=00", {err, wbValid}); end
    endtask

    task automatic test_ack_idle;
        memAck = 1'b1; memRdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        checks++;
        if ({wbValid, err, memReq, reqReady} !== 4'b0001) begin
            failures++;
            $display("FAIL ack_idle got=%b exp=0001", {wbValid, err, memReq, reqReady});
        end
        memAck = 1'b0; memRdata = 32'h0;
    endtask

    task automatic test_misalign;
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 5'd6);
        @(negedge clk);
        reqValid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        checks++;
        if ({memReq, err, wbValid, wbRegWe} !== 4'b0110) begin
            failures++;
            $display("FAIL misalign_trap got=%b exp=0110", {memReq, err, wbValid, wbRegWe});
        end
        @(negedge clk);
`else
        checks++;
        if ({memReq, memAddr, memBe} !== {1'b1, 32'h100, 4'b1111}) begin
            failures++;
            $display("FAIL misalign_bus got=%b %h %b exp=1 00000100 1111", memReq, memAddr, memBe);
        end
        memAck = 1'b1; memRdata = 32'h1122_3344;
        @(negedge clk);
        memAck = 1'b0; memRdata = 32'h0;
        checks++;
        if ({wbValid, wbRegWe, wbData, err} !== {1'b1, 1'b1, 32'h1122_3344, 1'b0}) begin
            failures++;
            $display("FAIL misalign_wb got=%b %b %h %b exp=1 1 11223344 0", wbValid, wbRegWe, wbData, err);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_bus;
        bit wb_seen = 0;
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 1'b1, 5'd8);
        @(negedge clk);
        reqValid = 1'b0;
        #2 resetIn = 1'b0;
        #1;
        checks++;
        if ({memReq, reqReady} !== 2'b00) begin failures++; $display("FAIL rst_mid_bus got=%b exp=00", {memReq, reqReady}); end
        memAck = 1'b1;
        repeat (2) begin @(negedge clk); if (wbValid) wb_seen = 1; end
        memAck = 1'b0;
        resetIn = 1'b1;
        @(negedge clk);
        if (wbValid) wb_seen = 1;
        checks++;
        if (wb_seen || reqReady !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_release got=wb%0d ready%b exp=wb0 ready1", wb_seen, reqReady);
        end
        drive_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_CAFE, 32'h0, 1'b1, 5'd3);
        @(negedge clk);
        reqValid = 1'b0;
        checks++;
        if ({wbValid, wbRegWe, wbRegAddr, wbData} !== {1'b1, 1'b1, 5'd3, 32'h0000_CAFE}) begin
            failures++;
            $display("FAIL rst_mid_pass got=%b %b %0d %h exp=1 1 3 0000cafe", wbValid, wbRegWe, wbRegAddr, wbData);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store_byte();
        test_load("ldh_s", 2'b01, 1'b0, 32'h0000_0202, 32'h8001_0000, 3, 4'b1100, 32'hFFFF_8001);
        test_load("ldh_u", 2'b01, 1'b1, 32'h0000_0202, 32'h8001_0000, 3, 4'b1100, 32'h0000_8001);
        test_load("ldb_s", 2'b00, 1'b0, 32'h0000_0101, 32'h0000_9C00, 0, 4'b0010, 32'hFFFF_FF9C);
        test_load("ldw_11", 2'b11, 1'b0, 32'h0000_0208, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678);
        test_timeout();
        test_ack_idle();
        test_misalign();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
